// File: rtl/dmem_store_merge_ctrl_pkg.sv
// Shared types and helpers for the data-memory store-merge controller:
// FSM encoding, byte-lane constants and funct3 legality/mask decode.
package dmem_store_merge_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_WAIT = 3'd1,
        S_RMW_RD  = 3'd2,
        S_RMW_WR  = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    localparam logic [2:0] FNC_LB  = 3'd0;
    localparam logic [2:0] FNC_LH  = 3'd1;
    localparam logic [2:0] FNC_LW  = 3'd2;
    localparam logic [2:0] FNC_LBU = 3'd4;
    localparam logic [2:0] FNC_LHU = 3'd5;
    localparam logic [2:0] FNC_SB  = 3'd0;
    localparam logic [2:0] FNC_SH  = 3'd1;
    localparam logic [2:0] FNC_SW  = 3'd2;

    function automatic logic fnc_legal(
        input logic       we,
        input logic [2:0] funct,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (funct)
                FNC_SB:  ok = 1'b1;
                FNC_SH:  ok = (off != 2'd3);
                FNC_SW:  ok = (off == 2'd0);
                default: ok = 1'b0;
            endcase
        end else begin
            case (funct)
                FNC_LB, FNC_LBU: ok = 1'b1;
                FNC_LH, FNC_LHU: ok = (off != 2'd3);
                FNC_LW:          ok = (off == 2'd0);
                default:         ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [MASK_W-1:0] byte_mask(
        input logic [2:0] funct,
        input logic [1:0] off
    );
        logic [MASK_W-1:0] m;
        case (funct)
            FNC_SB:  m = 4'b0001 << off;
            FNC_SH:  m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_store_merge_ctrl_store_byte_merge.sv
// Byte-lane merge of new store data into the old memory word.
module store_byte_merge
    import dmem_store_merge_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [MASK_W-1:0] mask,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_store_merge_ctrl.sv
// Memory-side load/store responder for a word-only SRAM; sub-word
// stores are turned into a read-modify-write pair.
module dmem_store_merge_ctrl
    import dmem_store_merge_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic              legal;
    logic              is_sw;
    logic [ADDR_W-1:0] req_word;
    logic [ADDR_W-1:0] addr_q;
    logic [MASK_W-1:0] mask_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ld_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] merged;
    logic              unused_addr_hi;

    // Upper address bits alias onto the SRAM; they are deliberately dropped.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign req_word  = req_addr[ADDR_W+1:2];
    assign legal     = fnc_legal(req_we, req_funct, req_addr[1:0]);
    assign is_sw     = req_we && (req_funct == FNC_SW);
    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    store_byte_merge u_merge (
        .old_word (mem_rdata),
        .new_word (wdata_q),
        .mask     (mask_q),
        .merged   (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        state_nx = S_ERR;
                    end else if (!req_we || is_sw) begin
                        state_nx = S_LD_WAIT;
                    end else begin
                        state_nx = S_RMW_RD;
                    end
                end
            end
            S_RMW_RD:  state_nx = S_RMW_WR;
            S_LD_WAIT: state_nx = S_IDLE;
            S_RMW_WR:  state_nx = S_IDLE;
            S_ERR:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            ld_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_word;
                mask_q  <= byte_mask(req_funct, req_addr[1:0]);
                wdata_q <= req_wdata;
                ld_q    <= !req_we;
            end
            if (state == S_LD_WAIT && ld_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = rdata_q;
        unique case (state)
            S_IDLE: begin
                if (accept && legal) begin
                    mem_en    = 1'b1;
                    mem_we    = is_sw;
                    mem_addr  = req_word;
                    mem_wdata = is_sw ? req_wdata : '0;
                end
            end
            S_LD_WAIT: begin
                resp_valid = 1'b1;
                if (ld_q) begin
                    resp_rdata = mem_rdata;
                end
            end
            S_RMW_RD: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merged;
            end
            S_RMW_WR: begin
                resp_valid = 1'b1;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

endmodule
